// File: rtl/demux_8_collect.sv
// rtl/demux_8_collect.sv - 1:8 stream-to-frame collector with valid/ready frame handshake
module demux_8_collect #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             flush,
   output logic [WIDTH-1:0] out0,
   output logic [WIDTH-1:0] out1,
   output logic [WIDTH-1:0] out2,
   output logic [WIDTH-1:0] out3,
   output logic [WIDTH-1:0] out4,
   output logic [WIDTH-1:0] out5,
   output logic [WIDTH-1:0] out6,
   output logic [WIDTH-1:0] out7,
   output logic [7:0]       slot_mask,
   output logic [2:0]       select,
   output logic             out_valid,
   input  logic             out_ready
);

   typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [2:0]       sel_q, sel_d;
   logic [7:0]       mask_q, mask_d;
   logic [WIDTH-1:0] lane_q [8];
   logic [WIDTH-1:0] lane_d [8];
   logic             accept;

   assign out_valid = (state_q == FULL);
   assign in_ready  = !out_valid || out_ready;
   assign accept    = in_valid && in_ready && !flush;

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      mask_d  = mask_q;
      for (int i = 0; i < 8; i++) lane_d[i] = lane_q[i];

      if (flush) begin
         state_d = FILL;
         sel_d   = 3'd0;
         mask_d  = 8'd0;
         for (int i = 0; i < 8; i++) lane_d[i] = '0;
      end else begin
         // Release first so a same-cycle accept starts the next frame's mask.
         if (state_q == FULL && out_ready) begin
            state_d = FILL;
            mask_d  = 8'd0;
         end
         if (accept) begin
            lane_d[sel_q]  = data_in;
            mask_d[sel_q]  = 1'b1;
            sel_d          = sel_q + 3'd1;
            if (sel_q == 3'd7) state_d = FULL;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= FILL;
         sel_q   <= 3'd0;
         mask_q  <= 8'd0;
         for (int i = 0; i < 8; i++) lane_q[i] <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         mask_q  <= mask_d;
         for (int i = 0; i < 8; i++) lane_q[i] <= lane_d[i];
      end
   end

   assign slot_mask = mask_q;
   assign select    = sel_q;
   assign out0      = lane_q[0];
   assign out1      = lane_q[1];
   assign out2      = lane_q[2];
   assign out3      = lane_q[3];
   assign out4      = lane_q[4];
   assign out5      = lane_q[5];
   assign out6      = lane_q[6];
   assign out7      = lane_q[7];

endmodule

// File: tb/tb_demux_8_collect.sv
// tb/tb_demux_8_collect.sv - vector table, directed corner sequences and random model check for demux_8_collect
module tb_demux_8_collect;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] data_in;
   logic        in_valid, in_ready, flush, out_valid, out_ready;
   logic [31:0] out0, out1, out2, out3, out4, out5, out6, out7;
   logic [7:0]  slot_mask;
   logic [2:0]  select;
   logic [31:0] outs [8];

   int checks = 0;
   int errors = 0;

   demux_8_collect #(.WIDTH(32)) dut (
      .clock(clock), .reset(reset), .data_in(data_in), .in_valid(in_valid),
      .in_ready(in_ready), .flush(flush),
      .out0(out0), .out1(out1), .out2(out2), .out3(out3),
      .out4(out4), .out5(out5), .out6(out6), .out7(out7),
      .slot_mask(slot_mask), .select(select), .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clock = ~clock;

   assign outs[0] = out0; assign outs[1] = out1; assign outs[2] = out2; assign outs[3] = out3;
   assign outs[4] = out4; assign outs[5] = out5; assign outs[6] = out6; assign outs[7] = out7;

   typedef struct {
      logic        vld;
      logic [31:0] din;
      logic        ordy;
      logic        fl;
      logic        exp_valid;
      logic [2:0]  exp_sel;
      logic [7:0]  exp_mask;
      logic        exp_rdy;
      int          lane_idx;
      logic [31:0] lane_val;
   } vec_t;

   vec_t vecs [14];

   // Model state: words held in the current frame and the lane contents.
   int          m_cnt;
   logic [31:0] m_lane [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] d, input logic r, input logic f);
      in_valid = v; data_in = d; out_ready = r; flush = f;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check_model(input string tag);
      chk({tag, " out_valid"}, {31'd0, out_valid}, {31'd0, m_cnt == 8});
      chk({tag, " select"}, {29'd0, select}, m_cnt % 8);
      chk({tag, " slot_mask"}, {24'd0, slot_mask},
          (m_cnt == 8) ? 32'hFF : ((32'd1 << m_cnt) - 32'd1));
      for (int i = 0; i < 8; i++) chk({tag, " lane"}, outs[i], m_lane[i]);
   endtask

   initial begin
      reset = 1'b0;
      drive(0, 0, 0, 0);

      for (int i = 0; i < 8; i++)
         vecs[i] = '{1, i, 0, 0, i == 7, 3'((i + 1) % 8), 8'((1 << (i + 1)) - 1), i < 7, i, i};
      for (int i = 8; i < 13; i++)
         vecs[i] = '{1, 99, 0, 0, 1, 0, 8'hFF, 0, i - 8, i - 8};
      vecs[13] = '{1, 42, 1, 0, 0, 1, 8'h01, 1, 0, 42};

      #12;
      chk("reset out_valid", {31'd0, out_valid}, 0);
      chk("reset select", {29'd0, select}, 0);
      chk("reset slot_mask", {24'd0, slot_mask}, 0);
      chk("reset out3", out3, 0);
      reset = 1'b1;
      tick();

      // Fill, backpressure, release-with-write
      for (int k = 0; k < 14; k++) begin
         drive(vecs[k].vld, vecs[k].din, vecs[k].ordy, vecs[k].fl);
         tick();
         chk("vec out_valid", {31'd0, out_valid}, {31'd0, vecs[k].exp_valid});
         chk("vec select", {29'd0, select}, {29'd0, vecs[k].exp_sel});
         chk("vec slot_mask", {24'd0, slot_mask}, {24'd0, vecs[k].exp_mask});
         chk("vec in_ready", {31'd0, in_ready}, {31'd0, vecs[k].exp_rdy});
         chk("vec lane", outs[vecs[k].lane_idx], vecs[k].lane_val);
      end
      for (int i = 1; i < 8; i++) chk("stale lane kept", outs[i], i);

      // Flush mid-frame beats a concurrent valid word
      foreach (vecs[i]) ;
      for (int i = 0; i < 3; i++) begin drive(1, 10 + i, 0, 0); tick(); end
      chk("pre-flush select", {29'd0, select}, 4);
      drive(1, 13, 0, 1);
      tick();
      drive(0, 0, 0, 0);
      chk("flush select", {29'd0, select}, 0);
      chk("flush slot_mask", {24'd0, slot_mask}, 0);
      chk("flush out_valid", {31'd0, out_valid}, 0);
      for (int i = 0; i < 8; i++) chk("flush lane", outs[i], 0);

      // Asynchronous reset between edges
      for (int i = 0; i < 5; i++) begin drive(1, 50 + i, 0, 0); tick(); end
      drive(0, 0, 0, 0);
      #2 reset = 1'b0;
      #1;
      chk("async select", {29'd0, select}, 0);
      chk("async slot_mask", {24'd0, slot_mask}, 0);
      for (int i = 0; i < 5; i++) chk("async lane", outs[i], 0);
      tick();
      #2 reset = 1'b1;
      for (int i = 0; i < 8; i++) begin drive(1, 200 + i, 0, 0); tick(); end
      drive(0, 0, 0, 0);
      chk("refill out_valid", {31'd0, out_valid}, 1);
      for (int i = 0; i < 8; i++) chk("refill lane", outs[i], 200 + i);
      drive(0, 0, 1, 0);
      tick();
      chk("release out_valid", {31'd0, out_valid}, 0);
      chk("release slot_mask", {24'd0, slot_mask}, 0);

      // Gapped input: select advances only on accepting edges
      begin
         int n_acc = 0;
         for (int c = 0; c < 16; c++) begin
            if (c % 2 == 0) drive(1, 100 + n_acc, 0, 0);
            else            drive(0, 32'hDEAD, 0, 0);
            tick();
            if (c % 2 == 0) n_acc++;
            chk("gap select", {29'd0, select}, n_acc % 8);
            chk("gap out_valid", {31'd0, out_valid}, {31'd0, n_acc == 8});
         end
         for (int i = 0; i < 8; i++) chk("gap lane", outs[i], 100 + i);
      end

      // Randomized traffic against the frame model
      drive(0, 0, 0, 1);
      tick();
      m_cnt = 0;
      for (int i = 0; i < 8; i++) m_lane[i] = 0;
      for (int c = 0; c < 400; c++) begin
         logic v, r, f, rdy;
         logic [31:0] d;
         v = ($urandom_range(0, 9) < 7);
         r = ($urandom_range(0, 9) < 4);
         f = ($urandom_range(0, 39) == 0);
         d = $urandom;
         drive(v, d, r, f);
         rdy = (m_cnt != 8) || r;
         #1;
         chk("rand in_ready", {31'd0, in_ready}, {31'd0, rdy});
         if (f) begin
            m_cnt = 0;
            for (int i = 0; i < 8; i++) m_lane[i] = 0;
         end else begin
            if (m_cnt == 8 && r) m_cnt = 0;
            if (v && rdy) begin
               m_lane[m_cnt] = d;
               m_cnt++;
            end
         end
         tick();
         check_model("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
